// File: rtl/dot_vector_feeder.sv
// -----------------------------------------------------------------------------
// dot_vector_feeder
//
// Streaming front end for the combinational scalar_product datapath. Operand
// pairs (a_i, b_i) arrive one per beat over a valid/ready handshake and are
// packed into flat vectors out_A/out_B (element i at [i*Nbits +: Nbits], the
// first accepted element in slot 0). Each complete vector pair is held in a
// registered valid/ready output stage. While the consumer holds the current
// vector, the assembly registers keep filling the next one.
//
// Parameters
//   Nbits  width of one element in bits
//   Ndata  elements per vector (must be >= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   element pair on in_a/in_b is valid
//   in_ready   element pair is accepted this cycle (never depends on in_valid)
//   in_a       element of vector A
//   in_b       element of vector B
//   out_valid  out_A/out_B hold a complete vector pair
//   out_ready  consumer takes the vector pair this cycle
//   out_A      packed vector A
//   out_B      packed vector B
//
// Optional build macro: FEEDER_LAST_CHECK_EN
//   Adds in_last (closes a vector early, remaining slots zero-padded) and
//   err_last (sticky flag set when the Ndata-th element lacks in_last).
// -----------------------------------------------------------------------------
module dot_vector_feeder #(
  parameter int Nbits = 4,
  parameter int Ndata = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [Nbits-1:0]       in_a,
  input  logic [Nbits-1:0]       in_b,
`ifdef FEEDER_LAST_CHECK_EN
  input  logic                   in_last,
  output logic                   err_last,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [Ndata*Nbits-1:0] out_A,
  output logic [Ndata*Nbits-1:0] out_B
);

  localparam int            CW       = $clog2(Ndata);
  localparam int            VW       = Ndata * Nbits;
  localparam logic [CW-1:0] CNT_LAST = CW'(Ndata - 1);

  // Element index of the next accepted pair.
  logic [CW-1:0] cnt;

  // Partially assembled vectors. Only slots 0..Ndata-2 are ever written; the
  // last element goes straight from in_a/in_b into the output register.
  logic [VW-1:0] asm_a;
  logic [VW-1:0] asm_b;

  // Complete vector as it would be loaded on a closing transfer.
  logic [VW-1:0] pack_a;
  logic [VW-1:0] pack_b;

  logic at_last;      // next element is the final slot
  logic out_blocked;  // output holds a vector the consumer is not taking
  logic close;        // an input transfer now would complete the vector
  logic in_fire;
  logic out_fire;

  assign at_last     = (cnt == CNT_LAST);
  assign out_blocked = out_valid && !out_ready;

  // in_ready is gated by rst_n so the source sees no acceptance while the
  // block is held in reset; otherwise it depends on registered state and
  // out_ready only.
`ifdef FEEDER_LAST_CHECK_EN
  // Any element may close a vector, so every transfer needs a free output.
  assign in_ready = rst_n && !out_blocked;
  assign close    = at_last || in_last;
`else
  // Only the final element needs room in the output register; earlier
  // elements land in the assembly registers and are always accepted.
  assign in_ready = rst_n && !(at_last && out_blocked);
  assign close    = at_last;
`endif

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Build the outgoing vector: slots below cnt come from the assembly
  // registers, slot cnt is the incoming element, slots above are zero. Stale
  // data left above cnt from an earlier vector is therefore never emitted,
  // which is what makes early close zero-padded without clearing asm_*.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pack_a = '0;
    pack_b = '0;
    for (int i = 0; i < Ndata; i++) begin
      if (CW'(i) == cnt) begin
        pack_a[i*Nbits +: Nbits] = in_a;
        pack_b[i*Nbits +: Nbits] = in_b;
      end else if (CW'(i) < cnt) begin
        pack_a[i*Nbits +: Nbits] = asm_a[i*Nbits +: Nbits];
        pack_b[i*Nbits +: Nbits] = asm_b[i*Nbits +: Nbits];
      end
    end
  end

  // Element counter and assembly registers.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  // NOTE: the assembly registers are plain flops, not a RAM, and are cleared
  // on reset so a partially assembled vector cannot leak out afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      asm_a <= '0;
      asm_b <= '0;
    end else if (in_fire) begin
      if (close) begin
        cnt <= '0;
      end else begin
        asm_a[cnt*Nbits +: Nbits] <= in_a;
        asm_b[cnt*Nbits +: Nbits] <= in_b;
        cnt                       <= cnt + CW'(1);
      end
    end
  end

  // Registered output stage. A closing transfer always reloads; this also
  // covers the simultaneous load-and-take case, where out_valid stays high
  // and vectors flow back to back. A take without a reload empties the stage
  // but leaves the data bits untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_A     <= '0;
      out_B     <= '0;
      out_valid <= 1'b0;
    end else if (in_fire && close) begin
      out_A     <= pack_a;
      out_B     <= pack_b;
      out_valid <= 1'b1;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FEEDER_LAST_CHECK_EN
  // Sticky framing error: the vector filled up without in_last on its final
  // element. The vector itself is still emitted normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_last <= 1'b0;
    end else if (in_fire && at_last && !in_last) begin
      err_last <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dot_vector_feeder.sv
// -----------------------------------------------------------------------------
// tb_dot_vector_feeder
//
// Scoreboard bench for dot_vector_feeder. A driver process feeds element pairs
// from a stimulus queue; each accepted pair goes to a reference model that
// collects elements in a list and, when a vector is complete, pushes the packed
// result (plain shift-and-or arithmetic) onto an expected queue. A separate
// monitor checks the output stage, in_ready and err_last every cycle and pops
// the expected queue on each output transfer.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dot_vector_feeder;

  localparam int NB = 4;
  localparam int ND = 4;
  localparam int VW = NB * ND;
  localparam int T  = 10;

`ifdef FEEDER_LAST_CHECK_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  typedef struct {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic          last;
  } stim_t;

  typedef struct {
    logic [VW-1:0] a;
    logic [VW-1:0] b;
  } vec_t;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [NB-1:0] in_a      = '0;
  logic [NB-1:0] in_b      = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_A;
  logic [VW-1:0] out_B;
`ifdef FEEDER_LAST_CHECK_EN
  logic          in_last   = 1'b0;
  logic          err_last;
`endif

  dot_vector_feeder #(.Nbits(NB), .Ndata(ND)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
`ifdef FEEDER_LAST_CHECK_EN
    .in_last  (in_last),
    .err_last (err_last),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_A    (out_A),
    .out_B    (out_B)
  );

  always #(T/2) clk = ~clk;

  // Scoreboard state
  stim_t         stim_q[$];
  logic [NB-1:0] cur_a[$];
  logic [NB-1:0] cur_b[$];
  vec_t          exp_q[$];
  bit            err_exp    = 1'b0;
  bit            gaps       = 1'b0;
  int            ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
  int            n_checks   = 0;
  int            n_fail     = 0;

  task automatic check(input string name, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a vector is the list of accepted elements, closed after
  // ND elements (or on in_last when enabled), packed LSB-first, zero-padded.
  task automatic model_accept(input stim_t s);
    vec_t v;
    cur_a.push_back(s.a);
    cur_b.push_back(s.b);
    if (cur_a.size() == ND || (LAST_EN && s.last)) begin
      v.a = '0;
      v.b = '0;
      for (int i = 0; i < cur_a.size(); i++) begin
        v.a = v.a | (VW'(cur_a[i]) << (i * NB));
        v.b = v.b | (VW'(cur_b[i]) << (i * NB));
      end
      if (LAST_EN && cur_a.size() == ND && !s.last) err_exp = 1'b1;
      exp_q.push_back(v);
      cur_a.delete();
      cur_b.delete();
    end
  endtask

  task automatic push(input int a, input int b, input bit last);
    stim_t s;
    s.a    = NB'(a);
    s.b    = NB'(b);
    s.last = last;
    stim_q.push_back(s);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && k < 500) begin
      @(posedge clk);
      k++;
    end
    check({name, "_drain"}, VW'(stim_q.size() == 0 && exp_q.size() == 0), 1);
    stim_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_checks(input string name);
    check({name, "_out_valid"}, VW'(out_valid), 0);
    check({name, "_in_ready"},  VW'(in_ready),  0);
    check({name, "_out_A"},     out_A,          0);
    check({name, "_out_B"},     out_B,          0);
  endtask

  // Driver: inputs change on the falling edge, acceptance is sampled just
  // before the rising edge and handed to the model after it.
  initial begin : driver
    stim_t s;
    bit    acc;
    forever begin
      @(negedge clk);
      if (stim_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        s        = stim_q[0];
        in_valid = 1'b1;
        in_a     = s.a;
        in_b     = s.b;
`ifdef FEEDER_LAST_CHECK_EN
        in_last  = s.last;
`endif
      end else begin
        in_valid = 1'b0;
        in_a     = NB'($urandom);
        in_b     = NB'($urandom);
`ifdef FEEDER_LAST_CHECK_EN
        in_last  = 1'($urandom_range(0, 1));
`endif
      end
      #(T/2 - 1);
      acc = in_valid && in_ready && rst_n;
      @(posedge clk);
      if (acc) begin
        void'(stim_q.pop_front());
        model_accept(s);
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: output stage must mirror the head of the expected queue and
  // in_ready must follow the back-pressure rule, every cycle.
  initial begin : monitor
    bit fire;
    bit ready_exp;
    forever begin
      @(negedge clk);
      #(T/2 - 1);
      check("out_valid", VW'(out_valid), VW'(rst_n && exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        check("out_A", out_A, exp_q[0].a);
        check("out_B", out_B, exp_q[0].b);
      end
      ready_exp = rst_n && !(exp_q.size() != 0 && !out_ready &&
                             (LAST_EN || cur_a.size() == ND - 1));
      check("in_ready", VW'(in_ready), VW'(ready_exp));
`ifdef FEEDER_LAST_CHECK_EN
      check("err_last", VW'(err_last), VW'(err_exp));
`endif
      fire = rst_n && out_valid && out_ready;
      @(posedge clk);
      if (fire && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  initial begin : watchdog
    #(200_000 * T);
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    // Power-on reset
    #1 rst_n = 1'b0;
    #1 reset_checks("por");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed vectors
    ready_mode = 1;
    gaps       = 1'b0;
    push(1, 6, 0); push(2, 5, 0); push(3, 4, 0); push(2, 1, 0);
    wait_idle("vec1");
    push(15, 15, 0); push(15, 15, 0); push(15, 15, 0); push(1, 1, 0);
    wait_idle("vec_max");

    // Back-pressure: consumer stalls while 8 pairs are offered
    ready_mode = 0;
    for (int i = 0; i < 8; i++) push($urandom, $urandom, 0);
    repeat (30) @(posedge clk);
    check("hold_pending", VW'(stim_q.size()), LAST_EN ? 4 : 1);
    ready_mode = 1;
    wait_idle("hold");

    // Continuous stream, no gaps
    for (int i = 0; i < 12; i++) push($urandom, $urandom, 0);
    wait_idle("stream");

    // Reset in the middle of a vector
    push(9, 9, 0); push(8, 8, 0);
    wait_idle("partial");
    @(negedge clk);
    #2 rst_n = 1'b0;
    cur_a.delete();
    cur_b.delete();
    exp_q.delete();
    err_exp = 1'b0;
    #1 reset_checks("mid_rst");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    push(3, 12, 0); push(4, 11, 0); push(5, 10, 0); push(6, 13, 0);
    wait_idle("fresh");

`ifdef FEEDER_LAST_CHECK_EN
    // Early close then a vector missing its in_last
    push(7, 3, 0); push(5, 2, 1);
    wait_idle("early_close");
    for (int i = 0; i < 4; i++) push($urandom, $urandom, 0);
    wait_idle("no_last");
`endif

    // Randomized traffic with random gaps and consumer stalls
    ready_mode = 2;
    gaps       = 1'b1;
    for (int i = 0; i < 80; i++)
      push($urandom, $urandom, LAST_EN && ($urandom_range(0, 4) == 0));
    wait_idle("random");
    ready_mode = 1;
    wait_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
